// File: rtl/alu_op_scheduler_if.sv
// Requester / ALU / display-side signals of the ALU op scheduler.
// slave = scheduler side, master = environment side.
interface alu_op_scheduler_if #(
   parameter int DROP_W = 8
);
   logic              uart_valid;
   logic [7:0]        uart_byte;
   logic [1:0]        uart_b;
   logic              loc_req;
   logic [3:0]        loc_a;
   logic [1:0]        loc_b;
   logic [1:0]        loc_sel;
   logic              loc_ack;
   logic [3:0]        alu_a;
   logic [1:0]        alu_b;
   logic [1:0]        alu_sel;
   logic [3:0]        alu_y;
   logic [3:0]        alu_flags;
   logic [3:0]        result;
   logic [3:0]        flags;
   logic              result_valid;
   logic [3:0]        duty;
   logic              grant_src;
   logic              busy;
   logic [DROP_W-1:0] drop_cnt;

   modport slave (
      input  uart_valid, uart_byte, uart_b, loc_req, loc_a, loc_b, loc_sel,
             alu_y, alu_flags,
      output loc_ack, alu_a, alu_b, alu_sel, result, flags, result_valid,
             duty, grant_src, busy, drop_cnt
   );

   modport master (
      output uart_valid, uart_byte, uart_b, loc_req, loc_a, loc_b, loc_sel,
             alu_y, alu_flags,
      input  loc_ack, alu_a, alu_b, alu_sel, result, flags, result_valid,
             duty, grant_src, busy, drop_cnt
   );
endinterface

// File: rtl/alu_op_scheduler.sv
// Arbitrates the shared 4-bit ALU between UART commands and the local requester,
// sequencing drive/settle/capture. ROUND_ROBIN_EN selects round-robin tie-break.
module alu_op_scheduler #(
   parameter int EXEC_CYCLES = 1,
   parameter int HOLD_CYCLES = 1000,
   parameter int DROP_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   alu_op_scheduler_if.slave bus
);
   localparam int MAXC = (EXEC_CYCLES > HOLD_CYCLES) ? EXEC_CYCLES : HOLD_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [3:0]        alu_a_q, alu_a_d;
   logic [1:0]        alu_b_q, alu_b_d;
   logic [1:0]        alu_sel_q, alu_sel_d;
   logic [3:0]        res_q, res_d;
   logic [3:0]        flg_q, flg_d;
   logic [3:0]        duty_q, duty_d;
   logic              rv_q, rv_d;
   logic              ack_q, ack_d;
   logic              src_q, src_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic              buf_full_q, buf_full_d;
   logic              buf_inf_q, buf_inf_d;
   logic [3:0]        buf_a_q, buf_a_d;
   logic [1:0]        buf_sel_q, buf_sel_d;
`ifdef ROUND_ROBIN_EN
   logic              last_q, last_d;
`endif

   logic grant, pick_u, grant_u;
   // Command byte bits [1:0] carry nothing for us.
   logic unused_byte_bits;
   assign unused_byte_bits = ^bus.uart_byte[1:0];

   // Buffer is registered, so a strobe can never win in its own cycle.
`ifdef ROUND_ROBIN_EN
   assign pick_u = buf_full_q && (!bus.loc_req || last_q);
`else
   assign pick_u = buf_full_q;
`endif
   assign grant   = (state_q == S_IDLE) && (buf_full_q || bus.loc_req);
   assign grant_u = grant && pick_u;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      res_d      = res_q;
      flg_d      = flg_q;
      duty_d     = duty_q;
      rv_d       = 1'b0;
      ack_d      = 1'b0;
      src_d      = src_q;
      drop_d     = drop_q;
      buf_full_d = buf_full_q;
      buf_inf_d  = buf_inf_q;
      buf_a_d    = buf_a_q;
      buf_sel_d  = buf_sel_q;
`ifdef ROUND_ROBIN_EN
      last_d     = last_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (grant) begin
               alu_a_d   = pick_u ? buf_a_q   : bus.loc_a;
               alu_b_d   = pick_u ? bus.uart_b : bus.loc_b;
               alu_sel_d = pick_u ? buf_sel_q : bus.loc_sel;
               src_d     = !pick_u;
               buf_inf_d = pick_u;
`ifdef ROUND_ROBIN_EN
               last_d    = !pick_u;
`endif
               cnt_d     = CW'(EXEC_CYCLES - 1);
               state_d   = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cnt_q == '0) begin
               res_d  = bus.alu_y;
               flg_d  = bus.alu_flags;
               duty_d = bus.alu_y;
               rv_d   = 1'b1;
               ack_d  = src_q;
               // The in-flight UART entry is released only once its result is taken.
               if (buf_inf_q) begin
                  buf_full_d = 1'b0;
                  buf_inf_d  = 1'b0;
               end
               cnt_d   = CW'(HOLD_CYCLES - 1);
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = S_IDLE;
      endcase

      // A strobe in the grant cycle refills the slot being handed to the ALU.
      if (bus.uart_valid) begin
         if (!buf_full_q || grant_u) begin
            buf_a_d    = bus.uart_byte[7:4];
            buf_sel_d  = bus.uart_byte[3:2];
            buf_full_d = 1'b1;
            buf_inf_d  = 1'b0;
         end else if (drop_q != {DROP_W{1'b1}}) begin
            drop_d = drop_q + DROP_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= '0;
         res_q      <= '0;
         flg_q      <= '0;
         duty_q     <= '0;
         rv_q       <= 1'b0;
         ack_q      <= 1'b0;
         src_q      <= 1'b0;
         drop_q     <= '0;
         buf_full_q <= 1'b0;
         buf_inf_q  <= 1'b0;
         buf_a_q    <= '0;
         buf_sel_q  <= '0;
`ifdef ROUND_ROBIN_EN
         last_q     <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_sel_q  <= alu_sel_d;
         res_q      <= res_d;
         flg_q      <= flg_d;
         duty_q     <= duty_d;
         rv_q       <= rv_d;
         ack_q      <= ack_d;
         src_q      <= src_d;
         drop_q     <= drop_d;
         buf_full_q <= buf_full_d;
         buf_inf_q  <= buf_inf_d;
         buf_a_q    <= buf_a_d;
         buf_sel_q  <= buf_sel_d;
`ifdef ROUND_ROBIN_EN
         last_q     <= last_d;
`endif
      end
   end

   assign bus.loc_ack      = ack_q;
   assign bus.alu_a        = alu_a_q;
   assign bus.alu_b        = alu_b_q;
   assign bus.alu_sel      = alu_sel_q;
   assign bus.result       = res_q;
   assign bus.flags        = flg_q;
   assign bus.result_valid = rv_q;
   assign bus.duty         = duty_q;
   assign bus.grant_src    = src_q;
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.drop_cnt     = drop_q;
endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler: expected ops queued at stimulus time,
// checked against each result_valid pulse.
module tb_alu_op_scheduler;
   localparam int EXEC_CYCLES = 1;
   localparam int HOLD_CYCLES = 4;
   localparam int DROP_W      = 8;
`ifdef ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_op_scheduler_if #(.DROP_W(DROP_W)) bus();

   alu_op_scheduler #(
      .EXEC_CYCLES(EXEC_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .DROP_W(DROP_W)
   ) dut (
      .clk(clk), .rst(rst_n), .bus(bus.slave)
   );

   // Reference ALU: returns {V,C,N,Z,y}.
   function automatic logic [7:0] alu_f(logic [3:0] a, logic [1:0] b, logic [1:0] sel);
      logic [4:0] s;
      logic [3:0] y;
      logic       v, c;
      s = '0; v = 1'b0; c = 1'b0;
      case (sel)
         2'd0: begin s = {1'b0, a} + {3'b0, b}; y = s[3:0]; c = s[4]; v = !a[3] && y[3]; end
         2'd1: begin s = {1'b0, a} - {3'b0, b}; y = s[3:0]; c = s[4]; v = a[3] && !y[3]; end
         2'd2: y = a & {2'b0, b};
         default: y = a ^ {2'b0, b};
      endcase
      return {v, c, y[3], (y == 4'd0), y};
   endfunction

   assign {bus.alu_flags, bus.alu_y} = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);

   typedef struct {
      logic       src;
      logic [3:0] a;
      logic [1:0] b;
      logic [1:0] sel;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   int   rv_cnt = 0;
   int   ack_cnt = 0;
   bit   sb_en = 1'b1;
   exp_t mon_e;
   logic [7:0] mon_r;

   always @(negedge clk) begin
      if (bus.loc_ack) ack_cnt++;
      if (bus.result_valid) begin
         rv_cnt++;
         if (sb_en) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_rv", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               mon_r = alu_f(mon_e.a, mon_e.b, mon_e.sel);
               chk("result", 32'(bus.result), 32'(mon_r[3:0]));
               chk("flags", 32'(bus.flags), 32'(mon_r[7:4]));
               chk("duty", 32'(bus.duty), 32'(mon_r[3:0]));
               chk("grant_src", 32'(bus.grant_src), 32'(mon_e.src));
               chk("loc_ack", 32'(bus.loc_ack), 32'(mon_e.src));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_u(logic [7:0] byt, logic [1:0] b);
      exp_t e;
      e.src = 1'b0; e.a = byt[7:4]; e.b = b; e.sel = byt[3:2];
      sb.push_back(e);
   endtask

   task automatic push_l(logic [3:0] a, logic [1:0] b, logic [1:0] sel);
      exp_t e;
      e.src = 1'b1; e.a = a; e.b = b; e.sel = sel;
      sb.push_back(e);
   endtask

   task automatic uart_strobe(logic [7:0] byt);
      bus.uart_valid = 1'b1;
      bus.uart_byte  = byt;
      tick();
      bus.uart_valid = 1'b0;
   endtask

   task automatic wait_rv(output int n);
      n = 0;
      while (1) begin
         @(negedge clk);
         n++;
         if (bus.result_valid) break;
         if (n >= 100) begin chk("rv_timeout", 32'd0, 32'd1); break; end
      end
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (1) begin
         @(negedge clk);
         n++;
         if (!bus.busy) break;
         if (n >= 100) begin chk("idle_timeout", 32'd0, 32'd1); break; end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_rv"}, 32'(bus.result_valid), 32'd0);
      chk({tag, "_ack"}, 32'(bus.loc_ack), 32'd0);
      chk({tag, "_res"}, 32'(bus.result), 32'd0);
      chk({tag, "_flags"}, 32'(bus.flags), 32'd0);
      chk({tag, "_duty"}, 32'(bus.duty), 32'd0);
      chk({tag, "_alu"}, 32'({bus.alu_a, bus.alu_b, bus.alu_sel}), 32'd0);
      chk({tag, "_src"}, 32'(bus.grant_src), 32'd0);
      chk({tag, "_drop"}, 32'(bus.drop_cnt), 32'd0);
   endtask

   logic [7:0] ub [4];
   bit         win_l [4];

   initial begin
      int n, m, a0, r0, uk;
      bus.uart_valid = 1'b0; bus.uart_byte = '0; bus.uart_b = '0;
      bus.loc_req = 1'b0; bus.loc_a = '0; bus.loc_b = '0; bus.loc_sel = '0;

      repeat (2) @(posedge clk);
      #1 chk_all_zero("por");
      rst_n = 1'b1;
      tick();

      // UART op: A=5 sel=3, B=2
      bus.uart_b = 2'd2;
      push_u(8'h5C, 2'd2);
      uart_strobe(8'h5C);
      wait_rv(n);
      chk("uart_latency", 32'(n), 32'(2 + EXEC_CYCLES));
      chk("uart_alu_ops", 32'({bus.alu_a, bus.alu_b, bus.alu_sel}), 32'({4'd5, 2'd2, 2'd3}));
      wait_idle(m);

      // Local op: A=9 B=1 sel=0
      tick();
      a0 = ack_cnt;
      bus.loc_a = 4'd9; bus.loc_b = 2'd1; bus.loc_sel = 2'd0; bus.loc_req = 1'b1;
      push_l(4'd9, 2'd1, 2'd0);
      wait_rv(n);
      bus.loc_req = 1'b0;
      wait_idle(m);
      chk("hold_len", 32'(m), 32'(HOLD_CYCLES));
      chk("ack_pulses", 32'(ack_cnt - a0), 32'd1);

      // Reset in the middle of EXEC
      tick();
      uart_strobe(8'hE4);
      n = 0;
      while (!bus.busy && n < 20) begin @(negedge clk); n++; end
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      r0 = rv_cnt;
      rst_n = 1'b0;
      #1 chk_all_zero("midrst");
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("midrst_no_rv", 32'(rv_cnt - r0), 32'd0);
      chk("midrst_idle", 32'(bus.busy), 32'd0);

      // Tie between buffered UART and local request, four times
      bus.uart_b = 2'd1;
      bus.loc_a = 4'd3; bus.loc_b = 2'd2; bus.loc_sel = 2'd1;
      ub[0] = 8'h70; ub[1] = 8'hA4; ub[2] = 8'hC8; ub[3] = 8'h6C;
      for (int i = 0; i < 4; i++) win_l[i] = RR && (i % 2 == 1);
      uk = 0;
      for (int i = 0; i < 4; i++) begin
         if (win_l[i]) push_l(4'd3, 2'd2, 2'd1);
         else begin push_u(ub[uk], 2'd1); uk++; end
      end
      if (RR) push_u(ub[uk], 2'd1);
      uart_strobe(ub[0]);
      bus.loc_req = 1'b1;
      uk = 1;
      for (int i = 0; i < 4; i++) begin
         wait_rv(n);
         if (i == 3) bus.loc_req = 1'b0;
         else if (!win_l[i]) begin
            tick();
            uart_strobe(ub[uk]);
            uk++;
         end
      end
      repeat (30) tick();
      chk("tie_sb_drained", 32'(sb.size()), 32'd0);

      // Overflow during HOLD, then saturation
      do_reset();
      bus.uart_b = 2'd2;
      push_u(8'h90, 2'd2);
      uart_strobe(8'h90);
      wait_rv(n);
      tick();
      push_u(8'h14, 2'd2);
      bus.uart_valid = 1'b1;
      bus.uart_byte = 8'h14; tick();
      bus.uart_byte = 8'h28; tick();
      bus.uart_byte = 8'h3C; tick();
      bus.uart_valid = 1'b0;
      chk("drop_after_3", 32'(bus.drop_cnt), 32'd2);
      wait_rv(n);
      wait_idle(m);
      tick();
      sb_en = 1'b0;
      bus.uart_valid = 1'b1;
      bus.uart_byte = 8'h48;
      repeat (500) tick();
      bus.uart_valid = 1'b0;
      repeat (30) tick();
      sb_en = 1'b1;
      chk("drop_saturated", 32'(bus.drop_cnt), 32'd255);

      // Strobe in the same IDLE cycle the buffer is granted
      do_reset();
      bus.uart_b = 2'd3;
      push_u(8'hB4, 2'd3);
      push_u(8'h5C, 2'd3);
      bus.uart_valid = 1'b1;
      bus.uart_byte = 8'hB4; tick();
      bus.uart_byte = 8'h5C; tick();
      bus.uart_valid = 1'b0;
      chk("simul_drop", 32'(bus.drop_cnt), 32'd0);
      wait_rv(n);
      wait_rv(n);
      chk("simul_drop_end", 32'(bus.drop_cnt), 32'd0);
      repeat (10) tick();
      chk("simul_sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
